ahb_cmd_queue: RTL



---
 rtl/ddr_ctrl_pkg.sv | 19 +
 rtl/cmd_fifo.sv | 64 ++++++
 rtl/ahb_cmd_queue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ddr_ctrl_pkg.sv
// Shared command format, AHB transfer encodings and FSM state type for the
// AHB-to-DDR3 command queue.
package ddr_ctrl_pkg;

    localparam int CMD_W       = 65;
    localparam int CMD_WR_BIT  = 64;
    localparam int CMD_ADDR_HI = 63;
    localparam int CMD_ADDR_LO = 32;
    localparam int CMD_DATA_HI = 31;
    localparam int CMD_DATA_LO = 0;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RDWAIT} cmdq_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead FIFO: rdata presents the head whenever non-empty, zero when empty.
// Storage is not reset; only pointers and count are.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 65
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A push into a full queue is only legal when a pop frees a slot at the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge ck) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ahb_cmd_queue.sv
// AHB-lite slave front end: each accepted transfer becomes one 65-bit DDR3
// command {wr, addr, wdata} queued for the downstream command controller.
module ahb_cmd_queue
    import ddr_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              hsel,
    input  logic [AW-1:0]     haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [DW-1:0]     hwdata,
    output logic              hready_out,
    output logic              hresp,
    input  logic              rd_done,
    input  logic              cmd_get,
    output logic              cmd_ready,
    output logic              cmd_valid,
    output logic [CMD_W-1:0]  cmd_data,
    output logic              pop_err
);

    cmdq_state_t          state_q, state_d;
    logic [AW-1:0]        haddr_q, haddr_d;
    logic                 hwrite_q, hwrite_d;
    logic                 pop_err_q;
    logic                 addr_req;
    logic                 push;
    logic [CMD_W-1:0]     push_data;
    logic                 fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    // NONSEQ/SEQ only; the hready_out qualification is applied per state below.
    assign addr_req  = hsel && htrans[1];
    assign push_data = {hwrite_q, haddr_q, hwrite_q ? hwdata : {DW{1'b0}}};

    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hready_out = 1'b1;
        push       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (addr_req) begin
                    haddr_d  = haddr;
                    hwrite_d = hwrite;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (fifo_full) begin
                    hready_out = 1'b0;
                end else begin
                    push = 1'b1;
                    if (hwrite_q) begin
                        if (addr_req) begin
                            haddr_d  = haddr;
                            hwrite_d = hwrite;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        hready_out = 1'b0;
                        state_d    = S_RDWAIT;
                    end
                end
            end
            S_RDWAIT: begin
                hready_out = rd_done;
                if (rd_done) begin
                    if (addr_req) begin
                        haddr_d  = haddr;
                        hwrite_d = hwrite;
                        state_d  = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q   <= S_IDLE;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            pop_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            if (cmd_get && fifo_empty) pop_err_q <= 1'b1;
        end
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .ck    (ck),
        .rst   (rst),
        .push  (push),
        .wdata (push_data),
        .pop   (cmd_get),
        .rdata (cmd_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cmd_ready = (fifo_count != '0);
    assign cmd_valid = cmd_ready;
    assign hresp     = 1'b0;
    assign pop_err   = pop_err_q;

endmodule
